regfile_sb: RTL and testbench

Parametrised register file with a per-register scoreboard. It generalises the core's 32x32, 2-read/1-write register file to N read ports and configurable depth and width. It also adds busy tracking for long-latency operations (loads, multiply/divide). It sits between decode/issue (read ports, claim port) and writeback (write port).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 71 +++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register file and its scoreboard.
// Default configuration: 32 registers of 32 bits, register 0 hardwired to zero.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with a sticky write-after-write error flag.
// A claim sets busy; a writeback clears it. On the same register in the same edge, the claim wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr_i,
  input  logic                        claim_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] claim_addr_i,
  output logic [NUM_REGS-1:0]         busy_vec_o,
  output logic                        waw_err_o
);

  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                waw_q, waw_d;
  logic                wr_act, claim_act, same_reg;

  assign wr_act    = wr_en_i && (wr_addr_i != ZERO_ADDR);
  assign claim_act = claim_en_i && (claim_addr_i != ZERO_ADDR);
  assign same_reg  = wr_en_i && (wr_addr_i == claim_addr_i);

  always_comb begin
    busy_d = busy_q;
    waw_d  = waw_q;
    if (wr_act) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    // Claim is applied after the clear so a reissue in the writeback cycle stays busy.
    if (claim_act) begin
      busy_d[claim_addr_i] = 1'b1;
      if (busy_q[claim_addr_i] && !same_reg) begin
        waw_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      waw_q  <= waw_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign waw_err_o  = waw_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with busy scoreboard; combinational reads, one writeback port, one claim port.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_READ   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_READ-1:0][$clog2(NUM_REGS)-1:0] rs_addr,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]       rs_data,
  output logic [NUM_READ-1:0]                       rs_busy,
  input  logic                                      wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]               wr_addr,
  input  logic [DATA_WIDTH-1:0]                     wr_data,
  input  logic                                      claim_en,
  input  logic [$clog2(NUM_REGS)-1:0]               claim_addr,
  output logic [NUM_REGS-1:0]                       busy_vec,
  output logic                                      waw_err
);

  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .claim_en_i   (claim_en),
    .claim_addr_i (claim_addr),
    .busy_vec_o   (busy_vec),
    .waw_err_o    (waw_err)
  );

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rs_busy[p] = busy_vec[rs_addr[p]];
      if (rs_addr[p] != ZERO_ADDR) begin
        rs_data[p] = regs_q[rs_addr[p]];
      end
`ifdef REGFILE_SB_BYPASS_EN
      // The forwarded value retires the claim, unless a reissue claims the same register.
      if (wr_en && (wr_addr != ZERO_ADDR) && (wr_addr == rs_addr[p])) begin
        rs_data[p] = wr_data;
        rs_busy[p] = claim_en && (claim_addr == wr_addr);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NP-1:0][AW-1:0]   rs_addr;
  logic [NP-1:0][DW-1:0]   rs_data;
  logic [NP-1:0]           rs_busy;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    claim_en;
  logic [AW-1:0]           claim_addr;
  logic [NR-1:0]           busy_vec;
  logic                    waw_err;

  int checks = 0;
  int errors = 0;
  bit model_ok = 1'b0;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_waw;

  regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rs_data    (rs_data),
    .rs_busy    (rs_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec),
    .waw_err    (waw_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model update at each rising edge from the inputs presented during that cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_busy   = '0;
      m_waw    = 1'b0;
      model_ok = 1'b1;
    end else begin
      if (claim_en && claim_addr != 0 && m_busy[claim_addr] && !(wr_en && wr_addr == claim_addr))
        m_waw = 1'b1;
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && a != 0 && wr_addr == a) return claim_en && (claim_addr == a);
`endif
    return m_busy[a];
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (model_ok && !rst) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model rs_data[%0d] addr %0d", p, rs_addr[p]), rs_data[p], exp_data(rs_addr[p]));
        check($sformatf("model rs_busy[%0d] addr %0d", p, rs_addr[p]), DW'(rs_busy[p]), DW'(exp_busy(rs_addr[p])));
      end
      check("model busy_vec", DW'(busy_vec), DW'(m_busy));
      check("model waw_err", DW'(waw_err), DW'(m_waw));
    end
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(); wr_addr = '0; wr_data = '0; claim_addr = '0; rs_addr = '0;
    to_pos(); to_pos();
    rst = 1'b0;

    // Reset sweep over every address on both ports
    for (int a = 0; a < NR; a++) begin
      rs_addr[0] = AW'(a); rs_addr[1] = AW'(NR - 1 - a);
      @(negedge clk);
      check("sweep rs_data0", rs_data[0], 32'h0);
      check("sweep rs_data1", rs_data[1], 32'h0);
      check("sweep rs_busy", DW'(rs_busy), 32'h0);
      to_pos();
    end
    check("reset busy_vec", DW'(busy_vec), 32'h0);
    check("reset waw_err", DW'(waw_err), 32'h0);

    // Write then read on both ports; x0 stays zero
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs_addr[0] = 5'd5; rs_addr[1] = 5'd5;
    to_pos(); idle();
    @(negedge clk);
    check("x5 port0", rs_data[0], 32'hDEADBEEF);
    check("x5 port1", rs_data[1], 32'hDEADBEEF);
    to_pos();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rs_addr[0] = 5'd0;
    to_pos(); idle();
    @(negedge clk);
    check("x0 reads zero", rs_data[0], 32'h0);
    to_pos();

    // Claim/write lifecycle on x7
    claim_en = 1'b1; claim_addr = 5'd7; rs_addr[1] = 5'd7;
    to_pos(); idle();
    @(negedge clk);
    check("x7 busy_vec", DW'(busy_vec[7]), 32'h1);
    check("x7 rs_busy", DW'(rs_busy[1]), 32'h1);
    to_pos();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    to_pos(); idle();
    @(negedge clk);
    check("x7 busy cleared", DW'(busy_vec[7]), 32'h0);
    check("x7 data", rs_data[1], 32'hA5A5A5A5);
    to_pos();

    // Simultaneous claim+write on x9; claim on x0 ignored
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099; claim_en = 1'b1; claim_addr = 5'd9;
    rs_addr[0] = 5'd9;
    to_pos(); idle();
    @(negedge clk);
    check("x9 busy kept", DW'(busy_vec[9]), 32'h1);
    check("x9 data", rs_data[0], 32'h00000099);
    check("x9 no waw", DW'(waw_err), 32'h0);
    to_pos();
    claim_en = 1'b1; claim_addr = 5'd0;
    to_pos(); idle();
    @(negedge clk);
    check("x0 never busy", DW'(busy_vec[0]), 32'h0);
    check("x0 claim no waw", DW'(waw_err), 32'h0);
    to_pos();

    // WAW: double claim of x3 sets the sticky flag
    claim_en = 1'b1; claim_addr = 5'd3;
    to_pos();
    to_pos(); idle();
    @(negedge clk);
    check("waw set", DW'(waw_err), 32'h1);
    check("x3 still busy", DW'(busy_vec[3]), 32'h1);
    to_pos();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    to_pos(); idle();
    @(negedge clk);
    check("waw sticky", DW'(waw_err), 32'h1);
    to_pos();

    // Write to x4 while port 0 reads it
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000CAFE; rs_addr[0] = 5'd4;
    @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
    check("x4 same cycle", rs_data[0], 32'h0000CAFE);
`else
    check("x4 same cycle", rs_data[0], 32'h0);
`endif
    to_pos(); idle();
    @(negedge clk);
    check("x4 next cycle", rs_data[0], 32'h0000CAFE);
    to_pos();

    // Reset mid-sequence drops claims, writes and the error flag
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55; claim_en = 1'b1; claim_addr = 5'd6;
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd6;
    to_pos(); rst = 1'b0; idle();
    @(negedge clk);
    check("rst busy_vec", DW'(busy_vec), 32'h0);
    check("rst waw_err", DW'(waw_err), 32'h0);
    check("rst x5", rs_data[0], 32'h0);
    to_pos();

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = AW'($urandom_range(0, NR - 1));
      wr_data    = $urandom;
      claim_en   = ($urandom_range(0, 2) == 0);
      claim_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      for (int p = 0; p < NP; p++)
        rs_addr[p] = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
      to_pos();
    end
    rst = 1'b0; idle();
    to_pos();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
